// File: rtl/gpu_display_sequencer.sv
// gpu_display_sequencer: sequences the VGA reset/settle/enable and stops or restarts only at frame boundaries.
// Optional GPU_SEQ_WATCHDOG_EN adds a frame_end watchdog that forces an automatic restart.
module gpu_display_sequencer #(
  parameter int CMD_WIDTH         = 8,
  parameter int START_CMD         = 2,
  parameter int STOP_CMD          = 3,
  parameter int RESTART_CMD       = 4,
  parameter int RESET_CYCLES      = 1,
  parameter int SETTLE_CYCLES     = 8,
  parameter int FRAME_COUNT_WIDTH = 16,
  parameter int WATCHDOG_CYCLES   = 1000000
) (
  input  logic                         system_clock,
  input  logic                         reset,
  input  logic                         command_valid,
  input  logic [CMD_WIDTH-1:0]         command,
  input  logic                         frame_end,
  output logic                         vga_reset,
  output logic                         vga_enable,
  output logic                         busy,
  output logic [2:0]                   state,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic                         cmd_error,
  output logic                         watchdog_fault
);
  localparam int PMAX = RESET_CYCLES > SETTLE_CYCLES ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int PW = $clog2(PMAX + 1);
  localparam logic [CMD_WIDTH-1:0] START_C = CMD_WIDTH'(START_CMD);
  localparam logic [CMD_WIDTH-1:0] STOP_C = CMD_WIDTH'(STOP_CMD);
  localparam logic [CMD_WIDTH-1:0] RESTART_C = CMD_WIDTH'(RESTART_CMD);
  typedef enum logic [2:0] {IDLE = 3'd0, RESET_PULSE = 3'd1, SETTLE = 3'd2, RUNNING = 3'd3, STOP_WAIT = 3'd4} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic pend_q, pend_d;
  logic [FRAME_COUNT_WIDTH-1:0] fc_q, fc_d;
  logic err_q, err_d;
  logic is_start, is_stop, is_restart;
  assign is_start = command_valid && command == START_C;
  assign is_stop = command_valid && command == STOP_C;
  assign is_restart = command_valid && command == RESTART_C;
  assign vga_reset = state_q == RESET_PULSE;
  assign vga_enable = state_q == RUNNING || state_q == STOP_WAIT;
  assign busy = state_q == RESET_PULSE || state_q == SETTLE || state_q == STOP_WAIT;
  assign state = state_q;
  assign frame_count = fc_q;
  assign cmd_error = err_q;
`ifdef GPU_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  logic [WW-1:0] wdt_q, wdt_d;
  logic wdog_q, wdog_d;
  assign watchdog_fault = wdog_q;
`else
  assign watchdog_fault = 1'b0 & |WATCHDOG_CYCLES;
`endif
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pend_d = pend_q;
    fc_d = frame_end && vga_enable ? fc_q + 1'b1 : fc_q;
    err_d = err_q | (command_valid && !(command == START_C || command == STOP_C || command == RESTART_C));
    case (state_q)
      IDLE: begin
        state_d = is_start ? RESET_PULSE : IDLE;
        phase_d = '0;
      end
      RESET_PULSE: begin
        state_d = is_stop ? IDLE : phase_q == PW'(RESET_CYCLES - 1) ? SETTLE : RESET_PULSE;
        phase_d = phase_q == PW'(RESET_CYCLES - 1) ? '0 : phase_q + 1'b1;
      end
      SETTLE: begin
        state_d = is_stop ? IDLE : phase_q == PW'(SETTLE_CYCLES - 1) ? RUNNING : SETTLE;
        phase_d = phase_q + 1'b1;
      end
      RUNNING: begin
        state_d = is_stop || is_restart ? STOP_WAIT : RUNNING;
        pend_d = is_restart && !is_stop;
      end
      STOP_WAIT: begin
        pend_d = is_restart ? 1'b1 : is_stop ? 1'b0 : pend_q;
        state_d = !frame_end ? STOP_WAIT : pend_d ? RESET_PULSE : IDLE;
        phase_d = '0;
        pend_d = pend_d && !frame_end;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        pend_d = 1'b0;
      end
    endcase
`ifdef GPU_SEQ_WATCHDOG_EN
    wdt_d = frame_end || !vga_enable ? '0 : wdt_q + 1'b1;
    wdog_d = wdog_q;
    // A stalled frame_end while the display runs forces a full restart.
    if (vga_enable && wdt_q == WW'(WATCHDOG_CYCLES - 1)) begin
      wdog_d = 1'b1;
      wdt_d = '0;
      state_d = RESET_PULSE;
      phase_d = '0;
      pend_d = 1'b0;
    end
`endif
  end
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      pend_q <= 1'b0;
      fc_q <= '0;
      err_q <= 1'b0;
`ifdef GPU_SEQ_WATCHDOG_EN
      wdt_q <= '0;
      wdog_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pend_q <= pend_d;
      fc_q <= fc_d;
      err_q <= err_d;
`ifdef GPU_SEQ_WATCHDOG_EN
      wdt_q <= wdt_d;
      wdog_q <= wdog_d;
`endif
    end
  end
endmodule

// File: tb/tb_gpu_display_sequencer.sv
// tb_gpu_display_sequencer: directed tests of the display sequencer with default parameters.
module tb_gpu_display_sequencer;
  logic system_clock = 1'b0;
  logic reset = 1'b1;
  logic command_valid = 1'b0;
  logic [7:0] command = 8'd0;
  logic frame_end = 1'b0;
  logic vga_reset, vga_enable, busy, cmd_error, watchdog_fault;
  logic [2:0] state;
  logic [15:0] frame_count;
  logic [5:0] obs;
  logic [15:0] fc0;
  int checks = 0;
  int fails = 0;

  gpu_display_sequencer dut (
    .system_clock(system_clock), .reset(reset), .command_valid(command_valid), .command(command),
    .frame_end(frame_end), .vga_reset(vga_reset), .vga_enable(vga_enable), .busy(busy), .state(state),
    .frame_count(frame_count), .cmd_error(cmd_error), .watchdog_fault(watchdog_fault)
  );

  always #5 system_clock = ~system_clock;
  assign obs = {state, vga_reset, vga_enable, busy};

  localparam logic [5:0] S_IDLE = {3'd0, 3'b000};
  localparam logic [5:0] S_RST = {3'd1, 3'b101};
  localparam logic [5:0] S_SET = {3'd2, 3'b001};
  localparam logic [5:0] S_RUN = {3'd3, 3'b010};
  localparam logic [5:0] S_STW = {3'd4, 3'b011};

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge system_clock);
      #1;
    end
  endtask

  task automatic cmd(input logic [7:0] code);
    command_valid = 1'b1;
    command = code;
    step(1);
    command_valid = 1'b0;
    command = 8'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic go_running();
    cmd(8'd2);
    step(9);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== S_IDLE || frame_count !== 16'd0 || cmd_error !== 1'b0 || watchdog_fault !== 1'b0) begin
      fails++;
      $display("FAIL reset: obs=%b fc=%0d err=%b wd=%b required obs=%b fc=0 err=0 wd=0", obs, frame_count, cmd_error, watchdog_fault, S_IDLE);
    end
  endtask

  task automatic test_start();
    cmd(8'd2);
    checks++;
    if (obs !== S_RST) begin fails++; $display("FAIL start_pulse: obs=%b required %b", obs, S_RST); end
    for (int i = 1; i <= 8; i++) begin
      step(1);
      checks++;
      if (obs !== S_SET) begin fails++; $display("FAIL start_settle%0d: obs=%b required %b", i, obs, S_SET); end
    end
    step(1);
    checks++;
    if (obs !== S_RUN) begin fails++; $display("FAIL start_run: obs=%b required %b", obs, S_RUN); end
    cmd(8'd2);
    checks++;
    if (obs !== S_RUN) begin fails++; $display("FAIL start_ignored_running: obs=%b required %b", obs, S_RUN); end
  endtask

  task automatic test_stop();
    fc0 = frame_count;
    cmd(8'd3);
    checks++;
    if (obs !== S_STW) begin fails++; $display("FAIL stop_wait: obs=%b required %b", obs, S_STW); end
    step(4);
    checks++;
    if (obs !== S_STW) begin fails++; $display("FAIL stop_hold: obs=%b required %b", obs, S_STW); end
    frame_end = 1'b1;
    step(1);
    frame_end = 1'b0;
    checks++;
    if (obs !== S_IDLE || frame_count !== fc0 + 16'd1) begin
      fails++;
      $display("FAIL stop_end: obs=%b fc=%0d required obs=%b fc=%0d", obs, frame_count, S_IDLE, fc0 + 16'd1);
    end
    frame_end = 1'b1;
    step(1);
    frame_end = 1'b0;
    checks++;
    if (frame_count !== fc0 + 16'd1) begin fails++; $display("FAIL fc_idle_hold: fc=%0d required %0d", frame_count, fc0 + 16'd1); end
  endtask

  task automatic test_restart();
    go_running();
    cmd(8'd4);
    checks++;
    if (obs !== S_STW) begin fails++; $display("FAIL restart_wait: obs=%b required %b", obs, S_STW); end
    frame_end = 1'b1;
    step(1);
    frame_end = 1'b0;
    checks++;
    if (obs !== S_RST) begin fails++; $display("FAIL restart_pulse: obs=%b required %b", obs, S_RST); end
    step(1);
    checks++;
    if (obs !== S_SET) begin fails++; $display("FAIL restart_settle: obs=%b required %b", obs, S_SET); end
    step(7);
    checks++;
    if (obs !== S_SET) begin fails++; $display("FAIL restart_settle_end: obs=%b required %b", obs, S_SET); end
    step(1);
    checks++;
    if (obs !== S_RUN) begin fails++; $display("FAIL restart_run: obs=%b required %b", obs, S_RUN); end
    cmd(8'd4);
    cmd(8'd3);
    frame_end = 1'b1;
    step(1);
    frame_end = 1'b0;
    checks++;
    if (obs !== S_IDLE) begin fails++; $display("FAIL restart_cancel: obs=%b required %b", obs, S_IDLE); end
  endtask

  task automatic test_abort_settle();
    cmd(8'd2);
    step(1);
    cmd(8'd3);
    checks++;
    if (obs !== S_IDLE) begin fails++; $display("FAIL abort_settle: obs=%b required %b", obs, S_IDLE); end
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (vga_enable !== 1'b0) begin fails++; $display("FAIL abort_no_enable%0d: en=%b required 0", i, vga_enable); end
    end
    cmd(8'd2);
    cmd(8'd4);
    checks++;
    if (obs !== S_SET) begin fails++; $display("FAIL restart_ignored_pulse: obs=%b required %b", obs, S_SET); end
    cmd(8'd3);
    cmd(8'd3);
    cmd(8'd4);
    checks++;
    if (obs !== S_IDLE) begin fails++; $display("FAIL idle_ignores_stop: obs=%b required %b", obs, S_IDLE); end
  endtask

  task automatic test_cmd_error();
    cmd(8'h55);
    checks++;
    if (cmd_error !== 1'b1 || obs !== S_IDLE) begin
      fails++;
      $display("FAIL err_idle: err=%b obs=%b required err=1 obs=%b", cmd_error, obs, S_IDLE);
    end
    do_reset();
    go_running();
    cmd(8'h55);
    checks++;
    if (cmd_error !== 1'b1 || obs !== S_RUN) begin
      fails++;
      $display("FAIL err_run: err=%b obs=%b required err=1 obs=%b", cmd_error, obs, S_RUN);
    end
    reset = 1'b1;
    command_valid = 1'b1;
    command = 8'h55;
    step(1);
    command_valid = 1'b0;
    reset = 1'b0;
    checks++;
    if (cmd_error !== 1'b0 || obs !== S_IDLE) begin
      fails++;
      $display("FAIL err_reset_drop: err=%b obs=%b required err=0 obs=%b", cmd_error, obs, S_IDLE);
    end
  endtask

  task automatic test_stop_same_frame();
    go_running();
    fc0 = frame_count;
    command_valid = 1'b1;
    command = 8'd3;
    frame_end = 1'b1;
    step(1);
    command_valid = 1'b0;
    frame_end = 1'b0;
    step(3);
    checks++;
    if (obs !== S_STW || frame_count !== fc0 + 16'd1) begin
      fails++;
      $display("FAIL stop_same_frame: obs=%b fc=%0d required obs=%b fc=%0d", obs, frame_count, S_STW, fc0 + 16'd1);
    end
    frame_end = 1'b1;
    step(1);
    frame_end = 1'b0;
    checks++;
    if (obs !== S_IDLE) begin fails++; $display("FAIL stop_same_frame_end: obs=%b required %b", obs, S_IDLE); end
  endtask

  task automatic test_wrap();
    do_reset();
    go_running();
    frame_end = 1'b1;
    step(65535);
    frame_end = 1'b0;
    checks++;
    if (frame_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_max: fc=%0h required ffff", frame_count); end
    frame_end = 1'b1;
    step(1);
    frame_end = 1'b0;
    checks++;
    if (frame_count !== 16'h0000 || obs !== S_RUN) begin
      fails++;
      $display("FAIL wrap_zero: fc=%0h obs=%b required fc=0 obs=%b", frame_count, obs, S_RUN);
    end
  endtask

  task automatic test_reset_mid_settle();
    do_reset();
    cmd(8'd2);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if (obs !== S_IDLE || frame_count !== 16'd0 || cmd_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_settle: obs=%b fc=%0d err=%b required obs=%b fc=0 err=0", obs, frame_count, cmd_error, S_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stop();
    test_restart();
    test_abort_settle();
    test_cmd_error();
    test_stop_same_frame();
    test_wrap();
    test_reset_mid_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/gpu_display_sequencer.md
Name: gpu_display_sequencer

Overview:
Parametrised control sequencer for the display path. It decodes single-byte MCU commands (start, stop, restart) and drives the VGA pipeline's reset and enable in a fixed order: reset pulse, FIFO settle, run. Stops and restarts happen only at frame boundaries, so the display never tears mid-frame. It sits between the message broker's command strobe and the vga instance, running on system_clock.

Parameters:
CMD_WIDTH, 8, width of command bus
START_CMD, 2, command code: start display
STOP_CMD, 3, command code: stop at next frame end
RESTART_CMD, 4, command code: stop at next frame end, then re-run start sequence
RESET_CYCLES, 1, cycles vga_reset held high (>=1)
SETTLE_CYCLES, 8, cycles waited after reset before enable (>=1)
FRAME_COUNT_WIDTH, 16, width of frame counter
WATCHDOG_CYCLES, 1000000, max cycles between frame_end strobes while running (used only with GPU_SEQ_WATCHDOG_EN)

Ports:
system_clock  input  1  sole clock
reset  input  1  synchronous, active-high reset
command_valid  input  1  one-cycle strobe; command is sampled on the same edge
command  input  CMD_WIDTH  command code
frame_end  input  1  one-cycle strobe from vga at end of frame (already in system_clock domain)
vga_reset  output  1  reset to vga/FIFO
vga_enable  output  1  enable to vga
busy  output  1  high in any state except IDLE and RUNNING
state  output  3  current state encoding
frame_count  output  FRAME_COUNT_WIDTH  frame_end strobes counted while vga_enable=1; wraps to 0
cmd_error  output  1  sticky: an unknown command code was received
watchdog_fault  output  1  sticky watchdog flag (always 0 when the feature is compiled out)

Behaviour:
- Reset (synchronous, active-high): state=IDLE(0), all counters 0, restart_pending=0, every output 0. Reset asserted in any state aborts the sequence immediately.
- States: IDLE=0, RESET_PULSE=1, SETTLE=2, RUNNING=3, STOP_WAIT=4. Encodings 5-7 are illegal and go to IDLE on the next edge.
- Outputs are decoded from the state register:
  - vga_reset = (state==RESET_PULSE)
  - vga_enable = (state==RUNNING || state==STOP_WAIT)
  - busy = (state is RESET_PULSE, SETTLE or STOP_WAIT)
- Per-state transitions (a command counts only when command_valid=1 on the edge):
  - IDLE: START_CMD -> RESET_PULSE and phase counter cleared. STOP_CMD and RESTART_CMD are ignored.
  - RESET_PULSE: stays RESET_CYCLES cycles -> SETTLE, phase counter cleared.
  - SETTLE: if counter==SETTLE_CYCLES-1 -> RUNNING, else counter+1.
  - Latency: vga_enable is first high RESET_CYCLES+SETTLE_CYCLES edges after the accepting edge (9 with defaults).
  - RESET_PULSE or SETTLE: STOP_CMD aborts -> IDLE next edge. START_CMD and RESTART_CMD are ignored.
  - RUNNING: STOP_CMD -> STOP_WAIT. RESTART_CMD -> STOP_WAIT and restart_pending=1. START_CMD is ignored.
  - STOP_WAIT: next frame_end -> RESET_PULSE if restart_pending (which then clears), else IDLE. RESTART_CMD sets restart_pending. STOP_CMD clears restart_pending.
- Simultaneous events:
  - frame_end on the same edge as the STOP/RESTART command in RUNNING is not the terminating strobe; STOP_WAIT waits for the next one. That frame_end is still counted.
- frame_count: +1 on each frame_end while vga_enable=1; wraps from all-ones to 0; held otherwise. Cleared only by reset.
- cmd_error: set when command_valid=1 and the code matches none of the three command codes, in any state. Sticky until reset. No state change.
- A command in the same cycle as reset is dropped.

Optional Feature:
GPU_SEQ_WATCHDOG_EN:
- Defined: a watchdog counter clears on entry to RUNNING and on every frame_end. It increments in RUNNING/STOP_WAIT. On reaching WATCHDOG_CYCLES-1:
  - watchdog_fault is set (sticky);
  - state -> RESET_PULSE (automatic restart);
  - restart_pending clears.
- Undefined: no watchdog logic; watchdog_fault tied to 0.

Test Plan:
- Reset, then command=2 strobe at edge 0 -> vga_reset high edges 0-1, busy high; vga_enable rises after edge 9; state=3.
- Running, command=3 at edge N, frame_end at N+5 -> vga_enable stays high until edge N+5, then 0; state=0; frame_count incremented by 1.
- Running, command=4, then frame_end -> state sequence 4,1,2,3; vga_reset pulses 1 cycle; vga_enable low for 9 cycles.
- Command=3 during SETTLE -> state=0 next edge, vga_enable never rises. Command=0x55 in any state -> cmd_error=1, state unchanged; reset clears it.
- 0xFFFF frame_end strobes while running (FRAME_COUNT_WIDTH=16), one more -> frame_count wraps to 0. STOP and frame_end in the same cycle -> remains STOP_WAIT until the next frame_end.
- With GPU_SEQ_WATCHDOG_EN and WATCHDOG_CYCLES=100, running with no frame_end -> at cycle 100 watchdog_fault=1, state=1; reset mid-SETTLE -> all outputs 0 next edge.
